btb_upd_sched: RTL and testbench

BTB_UPD_SCHED -- requirements
Module: btb_upd_sched

---
 rtl/btb_upd_sched_pkg.sv | 35 +++
 rtl/btb_upd_fifo.sv | 54 +++++
 rtl/btb_upd_sched.sv | 171 +++++++++++++++++
 tb/tb_btb_upd_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_upd_sched_pkg.sv
// Shared fetch definitions for BTB update scheduling: branch-type codes,
// retire-queue defaults, retire entry layout and the issue selector.
package btb_upd_sched_pkg;

  localparam int unsigned RQ_DEPTH_DEF = 4;
  localparam int unsigned AGE_MAX_DEF  = 7;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JUMP = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  // Which BTB write port gets the single write slot this cycle.
  typedef enum logic [1:0] {
    ISS_IDLE = 2'd0,
    ISS_SP   = 2'd1,
    ISS_RT   = 2'd2
  } issue_e;

  typedef struct packed {
    logic        brdir;
    logic [63:0] brpc;
    logic [63:0] brtar;
  } rt_upd_t;

  localparam int unsigned RT_UPD_W = $bits(rt_upd_t);

  // Saturating 16-bit increment used by the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Retire-update queue: registered storage with wrap-around pointers one bit
// wider than the index so full and empty can be told apart.
module btb_upd_fifo
  import btb_upd_sched_pkg::*;
#(
  parameter int unsigned DEPTH = RQ_DEPTH_DEF,
  parameter int unsigned WIDTH = RT_UPD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  // A push while full is dropped here even if a pop happens the same cycle;
  // the producer only sees ready once the pop has landed.
  assign full_o  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rd_ptr[AW-1:0]];

  // Write and read pointer advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/btb_upd_sched.sv
// BTB update scheduler: shares one BTB write per cycle between speculative
// allocates from fetch1 and queued retire updates, with an age-based
// starvation override for the retire queue.
module btb_upd_sched
  import btb_upd_sched_pkg::*;
#(
  parameter int unsigned RQ_DEPTH = RQ_DEPTH_DEF,
  parameter int unsigned AGE_MAX  = AGE_MAX_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sp_valid_i,
  input  logic [2:0]  sp_brpos_i,
  input  logic [1:0]  sp_brtyp_i,
  input  logic [63:0] sp_brpc_i,
  input  logic [63:0] sp_brtar_i,
  input  logic [1:0]  sp_rasctl_i,
  input  logic        flush_i,
  input  logic        rt_valid_i,
  output logic        rt_ready_o,
  input  logic        rt_brdir_i,
  input  logic [63:0] rt_brpc_i,
  input  logic [63:0] rt_brtar_i,
  output logic        btb_sp_we_o,
  output logic [2:0]  btb_sp_brpos_o,
  output logic [1:0]  btb_sp_brtyp_o,
  output logic [63:0] btb_sp_brpc_o,
  output logic [63:0] btb_sp_brtar_o,
  output logic [1:0]  btb_rasctl_o,
  output logic        btb_rt_we_o,
  output logic        btb_rt_brdir_o,
  output logic [63:0] btb_rt_brpc_o,
  output logic [63:0] btb_rt_brtar_o,
  output logic        sp_drop_o,
  output logic [15:0] drop_cnt_o
);

  localparam logic [2:0] AGE_LIM = 3'(AGE_MAX);

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_sp_req;
  logic                w_starve;
  logic                w_drop;
  issue_e              w_sel;
  rt_upd_t             w_rt_in;
  rt_upd_t             w_head;
  logic [RT_UPD_W-1:0] w_head_raw;

  logic [2:0]  r_age;
  logic        r_sp_we;
  logic [2:0]  r_sp_brpos;
  br_type_e    r_sp_brtyp;
  logic [63:0] r_sp_brpc;
  logic [63:0] r_sp_brtar;
  logic [1:0]  r_rasctl;
  logic        r_rt_we;
  logic        r_rt_brdir;
  logic [63:0] r_rt_brpc;
  logic [63:0] r_rt_brtar;
  logic        r_sp_drop;
  logic [15:0] r_drop_cnt;

  // Ready depends only on registered pointers, never on rt_valid_i.
  assign rt_ready_o = !w_full;
  assign w_push     = rt_valid_i && !w_full;
  assign w_sp_req   = sp_valid_i && !flush_i;
  assign w_rt_in    = '{brdir: rt_brdir_i, brpc: rt_brpc_i, brtar: rt_brtar_i};
  assign w_head     = rt_upd_t'(w_head_raw);

  btb_upd_fifo #(
    .DEPTH (RQ_DEPTH),
    .WIDTH (RT_UPD_W)
  ) u_rq (
    .clock       (clock),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i (w_rt_in),
    .pop_i       (w_pop),
    .head_o      (w_head_raw),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  // Write-slot arbitration: starved head, then live sp, then any head.
  always_comb begin
    w_sel    = ISS_IDLE;
    w_starve = !w_empty && (r_age == AGE_LIM);
    if (w_starve) begin
      w_sel = ISS_RT;
    end else if (w_sp_req) begin
      w_sel = ISS_SP;
    end else if (!w_empty) begin
      w_sel = ISS_RT;
    end
    w_pop  = (w_sel == ISS_RT);
    w_drop = w_starve && w_sp_req;
  end

  // Head age: counts cycles the head is passed over, saturating at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_age <= '0;
    end else if (w_pop || w_empty) begin
      r_age <= '0;
    end else if (r_age != AGE_LIM) begin
      r_age <= r_age + 3'd1;
    end
  end

  // Speculative BTB write port; payload held at zero when not writing.
  always_ff @(posedge clock) begin
    if (reset || (w_sel != ISS_SP)) begin
      r_sp_we    <= 1'b0;
      r_sp_brpos <= '0;
      r_sp_brtyp <= BR_NONE;
      r_sp_brpc  <= '0;
      r_sp_brtar <= '0;
      r_rasctl   <= '0;
    end else begin
      r_sp_we    <= 1'b1;
      r_sp_brpos <= sp_brpos_i;
      r_sp_brtyp <= br_type_e'(sp_brtyp_i);
      r_sp_brpc  <= sp_brpc_i;
      r_sp_brtar <= sp_brtar_i;
      r_rasctl   <= sp_rasctl_i;
    end
  end

  // Retire BTB write port driven from the queue head.
  always_ff @(posedge clock) begin
    if (reset || (w_sel != ISS_RT)) begin
      r_rt_we    <= 1'b0;
      r_rt_brdir <= 1'b0;
      r_rt_brpc  <= '0;
      r_rt_brtar <= '0;
    end else begin
      r_rt_we    <= 1'b1;
      r_rt_brdir <= w_head.brdir;
      r_rt_brpc  <= w_head.brpc;
      r_rt_brtar <= w_head.brtar;
    end
  end

  // Drop pulse and saturating drop count for sp requests lost to starvation.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sp_drop  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_sp_drop <= w_drop;
      if (w_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign btb_sp_we_o    = r_sp_we;
  assign btb_sp_brpos_o = r_sp_brpos;
  assign btb_sp_brtyp_o = r_sp_brtyp;
  assign btb_sp_brpc_o  = r_sp_brpc;
  assign btb_sp_brtar_o = r_sp_brtar;
  assign btb_rasctl_o   = r_rasctl;
  assign btb_rt_we_o    = r_rt_we;
  assign btb_rt_brdir_o = r_rt_brdir;
  assign btb_rt_brpc_o  = r_rt_brpc;
  assign btb_rt_brtar_o = r_rt_brtar;
  assign sp_drop_o      = r_sp_drop;
  assign drop_cnt_o     = r_drop_cnt;

endmodule

// File: tb/tb_btb_upd_sched.sv
// Bench for btb_upd_sched: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_btb_upd_sched;
  import btb_upd_sched_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AGEM  = 7;

  logic        clock = 1'b0;
  logic        reset;
  logic        sp_valid_i, flush_i, rt_valid_i, rt_ready_o, rt_brdir_i;
  logic [2:0]  sp_brpos_i;
  logic [1:0]  sp_brtyp_i, sp_rasctl_i;
  logic [63:0] sp_brpc_i, sp_brtar_i, rt_brpc_i, rt_brtar_i;
  logic        btb_sp_we_o, btb_rt_we_o, btb_rt_brdir_o, sp_drop_o;
  logic [2:0]  btb_sp_brpos_o;
  logic [1:0]  btb_sp_brtyp_o, btb_rasctl_o;
  logic [63:0] btb_sp_brpc_o, btb_sp_brtar_o, btb_rt_brpc_o, btb_rt_brtar_o;
  logic [15:0] drop_cnt_o;

  always #5 clock = ~clock;

  btb_upd_sched #(.RQ_DEPTH(DEPTH), .AGE_MAX(AGEM)) dut (
    .clock(clock), .reset(reset),
    .sp_valid_i(sp_valid_i), .sp_brpos_i(sp_brpos_i), .sp_brtyp_i(sp_brtyp_i),
    .sp_brpc_i(sp_brpc_i), .sp_brtar_i(sp_brtar_i), .sp_rasctl_i(sp_rasctl_i),
    .flush_i(flush_i), .rt_valid_i(rt_valid_i), .rt_ready_o(rt_ready_o),
    .rt_brdir_i(rt_brdir_i), .rt_brpc_i(rt_brpc_i), .rt_brtar_i(rt_brtar_i),
    .btb_sp_we_o(btb_sp_we_o), .btb_sp_brpos_o(btb_sp_brpos_o),
    .btb_sp_brtyp_o(btb_sp_brtyp_o), .btb_sp_brpc_o(btb_sp_brpc_o),
    .btb_sp_brtar_o(btb_sp_brtar_o), .btb_rasctl_o(btb_rasctl_o),
    .btb_rt_we_o(btb_rt_we_o), .btb_rt_brdir_o(btb_rt_brdir_o),
    .btb_rt_brpc_o(btb_rt_brpc_o), .btb_rt_brtar_o(btb_rt_brtar_o),
    .sp_drop_o(sp_drop_o), .drop_cnt_o(drop_cnt_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        dir;
    logic [63:0] pc;
    logic [63:0] tar;
  } ent_t;

  ent_t        mq[$];
  int          m_wait;
  logic        exp_sp_we, exp_rt_we, exp_drop, exp_ready, exp_rt_dir;
  logic [2:0]  exp_pos;
  logic [1:0]  exp_typ, exp_ras;
  logic [63:0] exp_sp_pc, exp_sp_tar, exp_rt_pc, exp_rt_tar;
  logic [15:0] exp_cnt;

  initial begin : model
    bit   sp_req, have, acc, starve, iss_rt, iss_sp;
    ent_t h, e;
    forever begin
      @(posedge clock);
      if (reset) begin
        mq.delete();
        m_wait = 0;
        exp_sp_we = 0; exp_pos = 0; exp_typ = 0; exp_sp_pc = 0; exp_sp_tar = 0; exp_ras = 0;
        exp_rt_we = 0; exp_rt_dir = 0; exp_rt_pc = 0; exp_rt_tar = 0;
        exp_drop = 0; exp_cnt = 0; exp_ready = 1;
      end else begin
        sp_req = sp_valid_i && !flush_i;
        have   = (mq.size() != 0);
        acc    = rt_valid_i && (mq.size() < DEPTH);
        starve = have && (m_wait == AGEM);
        iss_rt = starve || (have && !sp_req);
        iss_sp = !iss_rt && sp_req;
        exp_sp_we  = iss_sp;
        exp_pos    = iss_sp ? sp_brpos_i  : 3'd0;
        exp_typ    = iss_sp ? sp_brtyp_i  : 2'd0;
        exp_sp_pc  = iss_sp ? sp_brpc_i   : 64'd0;
        exp_sp_tar = iss_sp ? sp_brtar_i  : 64'd0;
        exp_ras    = iss_sp ? sp_rasctl_i : 2'd0;
        if (iss_rt) begin
          h = mq.pop_front();
          exp_rt_we = 1; exp_rt_dir = h.dir; exp_rt_pc = h.pc; exp_rt_tar = h.tar;
        end else begin
          exp_rt_we = 0; exp_rt_dir = 0; exp_rt_pc = 0; exp_rt_tar = 0;
        end
        exp_drop = starve && sp_req;
        if (exp_drop && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        if (iss_rt || !have) m_wait = 0;
        else if (m_wait < AGEM) m_wait = m_wait + 1;
        if (acc) begin
          e.dir = rt_brdir_i; e.pc = rt_brpc_i; e.tar = rt_brtar_i;
          mq.push_back(e);
        end
        exp_ready = (mq.size() < DEPTH);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("sp_we",    btb_sp_we_o,    exp_sp_we);
        chk("sp_brpos", btb_sp_brpos_o, exp_pos);
        chk("sp_brtyp", btb_sp_brtyp_o, exp_typ);
        chk("sp_brpc",  btb_sp_brpc_o,  exp_sp_pc);
        chk("sp_brtar", btb_sp_brtar_o, exp_sp_tar);
        chk("rasctl",   btb_rasctl_o,   exp_ras);
        chk("rt_we",    btb_rt_we_o,    exp_rt_we);
        chk("rt_brdir", btb_rt_brdir_o, exp_rt_dir);
        chk("rt_brpc",  btb_rt_brpc_o,  exp_rt_pc);
        chk("rt_brtar", btb_rt_brtar_o, exp_rt_tar);
        chk("sp_drop",  sp_drop_o,      exp_drop);
        chk("drop_cnt", drop_cnt_o,     exp_cnt);
        chk("rt_ready", rt_ready_o,     exp_ready);
        chk("one_we",   btb_sp_we_o & btb_rt_we_o, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    sp_valid_i = 0; flush_i = 0; rt_valid_i = 0;
    sp_brpos_i = 0; sp_brtyp_i = 0; sp_brpc_i = 0; sp_brtar_i = 0; sp_rasctl_i = 0;
    rt_brdir_i = 0; rt_brpc_i = 0; rt_brtar_i = 0;
  endtask

  task automatic set_sp(input logic [63:0] pc, input logic [63:0] tar,
                        input logic [2:0] pos, input logic [1:0] typ, input logic [1:0] ras);
    sp_valid_i = 1; sp_brpc_i = pc; sp_brtar_i = tar;
    sp_brpos_i = pos; sp_brtyp_i = typ; sp_rasctl_i = ras;
  endtask

  task automatic set_rt(input logic dir, input logic [63:0] pc, input logic [63:0] tar);
    rt_valid_i = 1; rt_brdir_i = dir; rt_brpc_i = pc; rt_brtar_i = tar;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int        n_spw, n_rtw, c_rt, n_drop;
    int        idx;
    int        acc_c[5];
    bit        rdy[20];
    logic [63:0] rt_pcs[$];

    idle_in();
    reset = 1;
    repeat (3) @(negedge clock);
    reset = 0;
    chk_en = 1;
    // reset state
    chk("rst_ready", rt_ready_o, 1);
    chk("rst_sp_we", btb_sp_we_o, 0);
    chk("rst_rt_we", btb_rt_we_o, 0);
    chk("rst_cnt",   drop_cnt_o, 0);

    // sp only: request at N, write at N+1
    @(negedge clock);
    set_sp(64'h1000, 64'h2000, 3'd5, BR_COND, 2'd1);
    @(negedge clock);
    idle_in();
    chk("s1_sp_we", btb_sp_we_o, 1);
    chk("s1_brpc",  btb_sp_brpc_o, 64'h1000);
    chk("s1_brtar", btb_sp_brtar_o, 64'h2000);
    chk("s1_brpos", btb_sp_brpos_o, 3'd5);
    chk("s1_rt_we", btb_rt_we_o, 0);
    @(negedge clock);
    chk("s1_off_we", btb_sp_we_o, 0);
    chk("s1_off_pc", btb_sp_brpc_o, 0);

    // retire only: 3 back-to-back pushes, writes two cycles later in order
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      if (c >= 2 && c <= 4) begin
        chk("s2_rt_we", btb_rt_we_o, 1);
        chk("s2_rt_pc", btb_rt_brpc_o, 64'hA000 + 64'(4 * (c - 2)));
      end else begin
        chk("s2_rt_idle", btb_rt_we_o, 0);
      end
      idle_in();
      if (c < 3) set_rt(c[0], 64'hA000 + 64'(4 * c), 64'hB000 + 64'(c));
    end

    // starvation: one queued update vs sp every cycle
    n_spw = 0; n_rtw = 0; c_rt = -1; n_drop = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      if (btb_sp_we_o) n_spw++;
      if (btb_rt_we_o) begin n_rtw++; c_rt = c; end
      if (sp_drop_o) n_drop++;
      idle_in();
      if (c == 0) set_rt(1'b1, 64'hC000, 64'hD000);
      else if (c <= 8) set_sp(64'h4000 + 64'(c), 64'h4800, 3'd1, BR_JUMP, 2'd0);
    end
    chk("s4_sp_writes", n_spw, 7);
    chk("s4_rt_writes", n_rtw, 1);
    chk("s4_rt_cycle",  c_rt, 9);
    chk("s4_drops",     n_drop, 1);
    chk("s4_drop_cnt",  drop_cnt_o, 1);
    chk("s4_model_cnt", exp_cnt, 1);

    // flush kills the same-cycle sp request without counting a drop
    @(negedge clock);
    set_sp(64'h5000, 64'h5800, 3'd2, BR_RET, 2'd3);
    flush_i = 1;
    @(negedge clock);
    idle_in();
    chk("s5_sp_we", btb_sp_we_o, 0);
    chk("s5_drop",  sp_drop_o, 0);
    chk("s5_cnt",   drop_cnt_o, 1);

    // full queue: five pushes under continuous sp
    idx = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clock);
      rdy[c] = rt_ready_o;
      if (btb_rt_we_o) rt_pcs.push_back(btb_rt_brpc_o);
      idle_in();
      if (c < 10) set_sp(64'h6000 + 64'(c), 64'h6800, 3'd0, BR_COND, 2'd0);
      if (idx < 5) begin
        set_rt(1'b0, 64'hE000 + 64'(8 * idx), 64'hF000 + 64'(idx));
        if (rt_ready_o) begin
          acc_c[idx] = c;
          idx++;
        end
      end
    end
    chk("s3_accepted", idx, 5);
    chk("s3_acc4_cycle", acc_c[3], 3);
    chk("s3_acc5_cycle", (idx == 5) ? acc_c[4] : -1, 9);
    for (int c = 4; c <= 8; c++) chk("s3_ready_low", rdy[c], 0);
    chk("s3_ready_back", rdy[9], 1);
    chk("s3_rt_count", rt_pcs.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("s3_rt_order", (k < rt_pcs.size()) ? rt_pcs[k] : 64'hDEAD, 64'hE000 + 64'(8 * k));

    // reset mid-operation discards queued updates
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      idle_in();
      set_sp(64'h7000 + 64'(c), 64'h7800, 3'd3, BR_JUMP, 2'd2);
      set_rt(1'b1, 64'h9000 + 64'(c), 64'h9800);
    end
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    idle_in();
    chk("s6_sp_we",   btb_sp_we_o, 0);
    chk("s6_rt_we",   btb_rt_we_o, 0);
    chk("s6_ready",   rt_ready_o, 1);
    chk("s6_cnt",     drop_cnt_o, 0);
    n_rtw = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (btb_rt_we_o) n_rtw++;
    end
    chk("s6_no_rt",   n_rtw, 0);
    chk("s6_ready2",  rt_ready_o, 1);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
